// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable UART with valid/ready byte interfaces.
// Optional feature macro: UART_CFG_PARITY_EN (parity generate/check; absent = no parity bit).
// Ports:
//   clk, rst_in                     clock, async active-high reset
//   baud_div_in, parity_mode_in,    per-frame configuration, latched at frame start
//   two_stop_in
//   tx_data_in/tx_valid_in/         TX byte handshake; tx_busy_out = !tx_ready_out
//   tx_ready_out/tx_busy_out
//   tx_serial_out                   TX pin, idle high
//   rx_serial_in                    RX pin, asynchronous
//   rx_data_out/rx_valid_out/       RX byte handshake with held error flags
//   rx_ready_in, rx_parity_err_out,
//   rx_frame_err_out
//   rx_overrun_out                  one-cycle pulse when a frame is dropped
module uart_cfg #(
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned OVERSAMPLING    = 16,
  parameter int unsigned DIV_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic [DIV_WIDTH-1:0] baud_div_in,
  input  logic [1:0]           parity_mode_in,
  input  logic                 two_stop_in,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic                 tx_valid_in,
  output logic                 tx_ready_out,
  output logic                 tx_busy_out,
  output logic                 tx_serial_out,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid_out,
  input  logic                 rx_ready_in,
  output logic                 rx_parity_err_out,
  output logic                 rx_frame_err_out,
  output logic                 rx_overrun_out
);
  localparam int unsigned OS_W = $clog2(OVERSAMPLING);
  localparam int unsigned BC_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLING - 1);
  localparam logic [OS_W-1:0] VOTE_0  = OS_W'(OVERSAMPLING / 2 - 1);
  localparam logic [OS_W-1:0] VOTE_1  = OS_W'(OVERSAMPLING / 2);
  localparam logic [OS_W-1:0] VOTE_2  = OS_W'(OVERSAMPLING / 2 + 1);
  localparam logic [BC_W-1:0] BC_DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] BC_DATA      = BC_W'(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Clock frequency is informational only; software derives the divisor.
  if (CLOCK_FREQUENCY == 0) begin : g_clock_frequency_unset
  end

  logic tx_par_en, tx_par_bit, rx_par_en;

  // ---------------- TX ----------------
  logic [2:0]           tx_state, tx_state_nx;
  logic [DIV_WIDTH-1:0] tx_div_q, tx_tick_cnt;
  logic [OS_W-1:0]      tx_os_cnt;
  logic [BC_W-1:0]      tx_bit_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_two_stop_q;
  logic                 tx_accept, tx_tick, tx_bit_end;

  assign tx_accept  = tx_valid_in && tx_ready_out;
  assign tx_tick    = (tx_tick_cnt == tx_div_q);
  assign tx_bit_end = tx_tick && (tx_os_cnt == OS_LAST);

  // TX next-state
  always_comb begin
    tx_state_nx = tx_state;
    case (tx_state)
      S_IDLE:   if (tx_accept) tx_state_nx = S_START;
      S_START:  if (tx_bit_end) tx_state_nx = S_DATA;
      S_DATA:   if (tx_bit_end && (tx_bit_cnt == BC_DATA_LAST))
                  tx_state_nx = tx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (tx_bit_end) tx_state_nx = S_STOP;
      // Second stop bit is the one with bit counter already at 1.
      S_STOP:   if (tx_bit_end && (tx_bit_cnt[0] || !tx_two_stop_q)) tx_state_nx = S_IDLE;
      default:  tx_state_nx = S_IDLE;
    endcase
  end

  // TX state and handshake outputs
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      tx_state     <= S_IDLE;
      tx_ready_out <= 1'b1;
      tx_busy_out  <= 1'b0;
    end else begin
      tx_state     <= tx_state_nx;
      tx_ready_out <= (tx_state_nx == S_IDLE);
      tx_busy_out  <= (tx_state_nx != S_IDLE);
    end
  end

  // TX datapath: tick/bit counters, shifter and pin
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      tx_div_q      <= '0;
      tx_tick_cnt   <= '0;
      tx_os_cnt     <= '0;
      tx_bit_cnt    <= '0;
      tx_shift      <= '0;
      tx_two_stop_q <= 1'b0;
      tx_serial_out <= 1'b1;
    end else if (tx_accept) begin
      tx_div_q      <= baud_div_in;
      tx_two_stop_q <= two_stop_in;
      tx_shift      <= tx_data_in;
      tx_tick_cnt   <= '0;
      tx_os_cnt     <= '0;
      tx_bit_cnt    <= '0;
      tx_serial_out <= 1'b0;
    end else if (tx_state != S_IDLE) begin
      tx_tick_cnt <= tx_tick ? '0 : tx_tick_cnt + 1'b1;
      if (tx_tick) tx_os_cnt <= (tx_os_cnt == OS_LAST) ? '0 : tx_os_cnt + 1'b1;
      if (tx_bit_end) begin
        case (tx_state)
          S_START: tx_serial_out <= tx_shift[0];
          S_DATA: begin
            if (tx_bit_cnt == BC_DATA_LAST) begin
              tx_bit_cnt    <= '0;
              tx_serial_out <= tx_par_en ? tx_par_bit : 1'b1;
            end else begin
              tx_bit_cnt    <= tx_bit_cnt + 1'b1;
              tx_shift      <= tx_shift >> 1;
              tx_serial_out <= tx_shift[1];
            end
          end
          S_PARITY: begin
            tx_bit_cnt    <= '0;
            tx_serial_out <= 1'b1;
          end
          S_STOP: begin
            tx_bit_cnt    <= tx_bit_cnt + 1'b1;
            tx_serial_out <= 1'b1;
          end
          default: tx_serial_out <= 1'b1;
        endcase
      end
    end
  end

  // ---------------- RX ----------------
  logic [1:0]           rx_sync;
  logic                 rx_prev;
  logic [2:0]           rx_state, rx_state_nx;
  logic [DIV_WIDTH-1:0] rx_div_q, rx_tick_cnt;
  logic [OS_W-1:0]      rx_os_cnt;
  logic [BC_W-1:0]      rx_bit_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_s0, rx_s1;
  logic                 rx_start, rx_tick, rx_bit_end, rx_vote, rx_maj, rx_done, rx_load;

  // Synchroniser plus one delay flop for start-edge detection; idle-high reset.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_serial_in};
      rx_prev <= rx_sync[1];
    end
  end

  assign rx_start   = (rx_state == S_IDLE) && rx_prev && !rx_sync[1];
  assign rx_tick    = (rx_tick_cnt == rx_div_q);
  assign rx_bit_end = rx_tick && (rx_os_cnt == OS_LAST);
  // Third vote sample is the live synchronised value, so the decision lands on that tick.
  assign rx_vote    = rx_tick && (rx_os_cnt == VOTE_2);
  assign rx_maj     = (rx_s0 & rx_s1) | (rx_s0 & rx_sync[1]) | (rx_s1 & rx_sync[1]);
  assign rx_done    = (rx_state == S_STOP) && rx_vote;
  assign rx_load    = rx_done && (!rx_valid_out || rx_ready_in);

  // RX next-state
  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_start) rx_state_nx = S_START;
      S_START:  if (rx_vote && rx_maj) rx_state_nx = S_IDLE;
                else if (rx_bit_end) rx_state_nx = S_DATA;
      S_DATA:   if (rx_bit_end && (rx_bit_cnt == BC_DATA))
                  rx_state_nx = rx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (rx_bit_end) rx_state_nx = S_STOP;
      S_STOP:   if (rx_vote) rx_state_nx = S_IDLE;
      default:  rx_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) rx_state <= S_IDLE;
    else        rx_state <= rx_state_nx;
  end

  // RX datapath: tick/bit counters, vote samples and data shifter
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      rx_div_q    <= '0;
      rx_tick_cnt <= '0;
      rx_os_cnt   <= '0;
      rx_bit_cnt  <= '0;
      rx_shift    <= '0;
      rx_s0       <= 1'b1;
      rx_s1       <= 1'b1;
    end else if (rx_state == S_IDLE) begin
      if (rx_start) begin
        rx_div_q    <= baud_div_in;
        rx_tick_cnt <= '0;
        rx_os_cnt   <= '0;
        rx_bit_cnt  <= '0;
      end
    end else begin
      rx_tick_cnt <= rx_tick ? '0 : rx_tick_cnt + 1'b1;
      if (rx_tick) rx_os_cnt <= (rx_os_cnt == OS_LAST) ? '0 : rx_os_cnt + 1'b1;
      if (rx_tick && (rx_os_cnt == VOTE_0)) rx_s0 <= rx_sync[1];
      if (rx_tick && (rx_os_cnt == VOTE_1)) rx_s1 <= rx_sync[1];
      if (rx_vote && (rx_state == S_DATA)) begin
        rx_shift   <= {rx_maj, rx_shift[DATA_BITS-1:1]};
        rx_bit_cnt <= rx_bit_cnt + 1'b1;
      end
    end
  end

  // RX output holding register; a completion while still held is dropped as overrun.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      rx_data_out      <= '0;
      rx_valid_out     <= 1'b0;
      rx_frame_err_out <= 1'b0;
      rx_overrun_out   <= 1'b0;
    end else begin
      rx_overrun_out <= rx_done && !rx_load;
      if (rx_load) begin
        rx_data_out      <= rx_shift;
        rx_frame_err_out <= !rx_maj;
        rx_valid_out     <= 1'b1;
      end else if (rx_ready_in) begin
        rx_valid_out <= 1'b0;
      end
    end
  end

`ifdef UART_CFG_PARITY_EN
  logic rx_par_odd, rx_par_bit;

  // Parity config per direction; mode[1] selects odd, so the bit is ^data ^ odd.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      tx_par_en         <= 1'b0;
      tx_par_bit        <= 1'b0;
      rx_par_en         <= 1'b0;
      rx_par_odd        <= 1'b0;
      rx_par_bit        <= 1'b0;
      rx_parity_err_out <= 1'b0;
    end else begin
      if (tx_accept) begin
        tx_par_en  <= (parity_mode_in == 2'b01) || (parity_mode_in == 2'b10);
        tx_par_bit <= (^tx_data_in) ^ parity_mode_in[1];
      end
      if (rx_start) begin
        rx_par_en  <= (parity_mode_in == 2'b01) || (parity_mode_in == 2'b10);
        rx_par_odd <= parity_mode_in[1];
      end
      if (rx_vote && (rx_state == S_PARITY)) rx_par_bit <= rx_maj;
      if (rx_load) rx_parity_err_out <= rx_par_en && ((^rx_shift) ^ rx_par_bit ^ rx_par_odd);
    end
  end
`else
  logic unused_parity_mode;

  assign tx_par_en          = 1'b0;
  assign tx_par_bit         = 1'b0;
  assign rx_par_en          = 1'b0;
  assign rx_parity_err_out  = 1'b0;
  assign unused_parity_mode = ^parity_mode_in;
`endif

endmodule

// File: tb/tb_uart_cfg.sv
`timescale 1ns/1ps
module tb_uart_cfg;
  localparam int unsigned DB = 8;
  localparam int unsigned DW = 16;
`ifdef UART_CFG_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] baud_div;
  logic [1:0]    parity_mode;
  logic          two_stop;
  logic [DB-1:0] tx_data;
  logic          tx_valid, tx_ready, tx_busy, tx_serial;
  logic          rx_serial;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_ready, rx_perr, rx_ferr, rx_ovr;
  logic          loop_en, bb_line;

  always #5 clk = ~clk;
  assign rx_serial = loop_en ? tx_serial : bb_line;

  uart_cfg #(.CLOCK_FREQUENCY(100_000_000), .DATA_BITS(DB), .OVERSAMPLING(16), .DIV_WIDTH(DW)) dut (
    .clk(clk), .rst_in(rst), .baud_div_in(baud_div), .parity_mode_in(parity_mode),
    .two_stop_in(two_stop), .tx_data_in(tx_data), .tx_valid_in(tx_valid),
    .tx_ready_out(tx_ready), .tx_busy_out(tx_busy), .tx_serial_out(tx_serial),
    .rx_serial_in(rx_serial), .rx_data_out(rx_data), .rx_valid_out(rx_valid),
    .rx_ready_in(rx_ready), .rx_parity_err_out(rx_perr), .rx_frame_err_out(rx_ferr),
    .rx_overrun_out(rx_ovr)
  );

  typedef struct packed { logic [7:0] data; logic perr; logic ferr; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, ovr_cnt = 0, rx_cnt = 0, pushed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe;
    sb.push_back(e);
    pushed++;
  endtask

  // Scoreboard consumer: every handshaken RX byte is compared against the queue head.
  always @(negedge clk) begin
    if (rx_ovr === 1'b1) ovr_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      check("rx_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.data));
        check("rx_perr", 32'(rx_perr), 32'(e.perr));
        check("rx_ferr", 32'(rx_ferr), 32'(e.ferr));
        rx_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tx_send(input logic [7:0] d);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 2000) begin step(1); t++; end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data = d; tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_txs"},  32'(tx_serial), 32'd1);
    check({tag, "_txr"},  32'(tx_ready),  32'd1);
    check({tag, "_txb"},  32'(tx_busy),   32'd0);
    check({tag, "_rxv"},  32'(rx_valid),  32'd0);
    check({tag, "_rxd"},  32'(rx_data),   32'd0);
    check({tag, "_pe"},   32'(rx_perr),   32'd0);
    check({tag, "_fe"},   32'(rx_ferr),   32'd0);
    check({tag, "_ovr"},  32'(rx_ovr),    32'd0);
  endtask

  // Transmit one byte at baud_div=0 and check pin level at start/middle/end of each bit.
  task automatic tx_frame_check(input logic [7:0] d, input logic [1:0] pm, input logic two);
    logic exp_bits [0:11];
    int n = 0, low = 0, bad_busy = 0;
    exp_bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin exp_bits[n] = d[i]; n++; end
    if (PAR && (pm == 2'b01 || pm == 2'b10)) begin exp_bits[n] = (^d) ^ pm[1]; n++; end
    exp_bits[n] = 1'b1; n++;
    if (two) begin exp_bits[n] = 1'b1; n++; end
    baud_div = '0; parity_mode = pm; two_stop = two;
    tx_send(d);
    for (int k = 0; k < n * 16 + 8; k++) begin
      @(negedge clk);
      if (k < n * 16 && (k % 16 == 0 || k % 16 == 8 || k % 16 == 15))
        check($sformatf("tx_%0h_pm%0d_bit%0d_k%0d", d, pm, k / 16, k % 16),
              32'(tx_serial), 32'(exp_bits[k / 16]));
      if (tx_ready !== 1'b1) low++;
      if (tx_busy !== ~tx_ready) bad_busy++;
    end
    check($sformatf("tx_busy_len_pm%0d_two%0d", pm, two), 32'(low), 32'(n * 16));
    check("tx_busy_inv", 32'(bad_busy), 32'd0);
  endtask

  // Bit-bang one RX frame at baud_div=0; gb selects a bit with a one-clock inversion at its centre.
  task automatic bb_frame(input logic [7:0] d, input logic [1:0] pm, input logic stop_v,
                          input logic flip, input int gb);
    logic bits [0:11];
    int n = 0;
    logic pen;
    pen = PAR && (pm == 2'b01 || pm == 2'b10);
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (pen) begin bits[n] = (^d) ^ pm[1] ^ flip; n++; end
    bits[n] = stop_v; n++;
    baud_div = '0; parity_mode = pm;
    push(d, pen && flip, !stop_v);
    for (int b = 0; b < n; b++)
      for (int c = 0; c < 16; c++) begin
        bb_line = bits[b] ^ ((b == gb) && (c == 9));
        step(1);
      end
    bb_line = 1'b1;
    step(24);
  endtask

  initial begin
    rst = 1'b1; baud_div = '0; parity_mode = 2'b00; two_stop = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1; loop_en = 1'b0; bb_line = 1'b1;
    step(3);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    step(4);
    check_reset_vals("post_reset");

    // TX frame shapes
    tx_frame_check(8'hA5, 2'b00, 1'b0);
    tx_frame_check(8'hA5, 2'b01, 1'b0);
    tx_frame_check(8'hA5, 2'b10, 1'b0);
    tx_frame_check(8'hA5, 2'b01, 1'b1);
    two_stop = 1'b0; parity_mode = 2'b00;

    // Loopback at baud_div=3
    loop_en = 1'b1; baud_div = 16'd3;
    step(10);
    push(8'h00, 1'b0, 1'b0); tx_send(8'h00);
    push(8'hFF, 1'b0, 1'b0); tx_send(8'hFF);
    push(8'h3C, 1'b0, 1'b0); tx_send(8'h3C);
    drain("loop_drain");

    // Overrun: consumer stalled across two frames
    step(20);
    rx_ready = 1'b0; ovr_cnt = 0;
    push(8'h00, 1'b0, 1'b0); tx_send(8'h00);
    tx_send(8'h55);
    step(700);
    check("ovr_count", 32'(ovr_cnt), 32'd1);
    check("ovr_held_valid", 32'(rx_valid), 32'd1);
    check("ovr_held_data", 32'(rx_data), 32'h00);
    rx_ready = 1'b1;
    drain("ovr_drain");

    // Bit-banged RX frames
    loop_en = 1'b0; bb_line = 1'b1;
    step(20);
    bb_frame(8'h5A, 2'b00, 1'b1, 1'b0, -1);
    bb_frame(8'hC3, 2'b00, 1'b0, 1'b0, -1);
    bb_frame(8'h00, 2'b00, 1'b0, 1'b0, -1);
    bb_frame(8'h96, 2'b00, 1'b1, 1'b0, 4);
`ifdef UART_CFG_PARITY_EN
    bb_frame(8'hA5, 2'b01, 1'b1, 1'b1, -1);
    bb_frame(8'hA5, 2'b10, 1'b1, 1'b0, -1);
    bb_frame(8'h37, 2'b10, 1'b1, 1'b1, -1);
`endif
    drain("bb_drain");

    // Short low glitch on the idle line is a false start
    bb_line = 1'b0; step(4); bb_line = 1'b1;
    step(300);
    check("glitch_no_valid", 32'(rx_valid), 32'd0);

    // Reset mid-TX and mid-RX with a held RX byte, then a clean frame
    loop_en = 1'b1; baud_div = '0; parity_mode = 2'b00; rx_ready = 1'b0;
    step(10);
    tx_send(8'h3C);
    step(200);
    check("pre_rst_held", 32'(rx_valid), 32'd1);
    tx_send(8'h81);
    step(50);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst");
    step(2);
    rst = 1'b0; rx_ready = 1'b1;
    step(5);
    push(8'h96, 1'b0, 1'b0); tx_send(8'h96);
    drain("rst_drain");

    step(20);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("rx_count", 32'(rx_cnt), 32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
